// File: rtl/alu_sequencer.sv
// Request-side controller for the combinational ALU: registers one operation per handshake,
// waits a settle interval, then holds the captured result on a backpressured response channel.
module alu_sequencer #(
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned SETTLE    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [3:0]           req_op_i,
    input  logic [DATA_SIZE-1:0] req_a_i,
    input  logic [DATA_SIZE-1:0] req_b_i,
    input  logic [2:0]           req_cond_i,
    output logic [DATA_SIZE-1:0] alu_a_o,
    output logic [DATA_SIZE-1:0] alu_b_o,
    output logic [3:0]           alu_op_o,
    input  logic [DATA_SIZE-1:0] alu_out_i,
    input  logic [2:0]           alu_comp_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATA_SIZE-1:0] rsp_data_o,
    output logic [2:0]           rsp_comp_o,
    output logic                 rsp_taken_o,
    output logic                 rsp_err_o
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic [3:0] SettleCnt = 4'(SETTLE);
    localparam logic [3:0] OpDiv     = 4'd7;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [2:0]           cond_q, cond_d;
    logic                 err_q, err_d;
    logic [DATA_SIZE-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]           alu_op_q, alu_op_d;
    logic [DATA_SIZE-1:0] rsp_data_q, rsp_data_d;
    logic [2:0]           rsp_comp_q, rsp_comp_d;
    logic                 rsp_taken_q, rsp_taken_d;
    logic                 rsp_err_q, rsp_err_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cond_q      <= '0;
            err_q       <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_data_q  <= '0;
            rsp_comp_q  <= '0;
            rsp_taken_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cond_q      <= cond_d;
            err_q       <= err_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_data_q  <= rsp_data_d;
            rsp_comp_q  <= rsp_comp_d;
            rsp_taken_q <= rsp_taken_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cond_d      = cond_q;
        err_d       = err_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_data_d  = rsp_data_q;
        rsp_comp_d  = rsp_comp_q;
        rsp_taken_d = rsp_taken_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    alu_a_d  = req_a_i;
                    alu_b_d  = req_b_i;
                    alu_op_d = req_op_i;
                    cond_d   = req_cond_i;
                    cnt_d    = SettleCnt;
                    // Opcodes 8..15 are undefined; DIV by zero is the only other error.
                    err_d    = req_op_i[3] || (req_op_i == OpDiv && req_b_i == '0);
                    state_d  = StExec;
                end
            end
            StExec: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = err_q ? '0 : alu_out_i;
                    rsp_comp_d  = alu_comp_i;
                    rsp_taken_d = |(alu_comp_i & cond_q);
                    rsp_err_d   = err_q;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_op_o    = alu_op_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_comp_o  = rsp_comp_q;
    assign rsp_taken_o = rsp_taken_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Request-side controller that drives the combinational ALU. It accepts one operation per valid/ready handshake and registers the operands and opcode onto the ALU inputs. After a programmable settle interval it captures the ALU result and 3-bit compare code, then presents them on a backpressured response channel. Division by zero and undefined opcodes are flagged, and a branch-taken bit is computed from a compare-condition mask. It sits between the instruction control path and the ALU.

## Interface
- DATA_SIZE, 16, operand/result width; matches the ALU data width.
- SETTLE, 1, extra cycles the ALU inputs are held before capture; legal range 0..15.

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  operation request valid.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_op  input  4  opcode:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT(A), 5 XOR, 6 signed MUL, 7 signed DIV.
  - 8..15 undefined.
- req_a, req_b  input  DATA_SIZE  operands.
- req_cond  input  3  taken-condition mask over the compare code {gt, eq, lt}.
- alu_a, alu_b  output  DATA_SIZE  registered operands to the ALU.
- alu_op  output  4  registered opcode to the ALU.
- alu_out  input  DATA_SIZE  ALU result.
- alu_comp  input  3  ALU compare code:
  - 100 = A>B signed.
  - 010 = A==B.
  - 001 = A<B signed.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  DATA_SIZE  captured result; forced to 0 on error.
- rsp_comp  output  3  captured compare code.
- rsp_taken  output  1  |(rsp_comp & latched cond).
- rsp_err  output  1  set for DIV with B==0, or for opcode >= 8.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_a/req_b/req_op into alu_a/alu_b/alu_op and req_cond into an internal register.
  - Load the settle counter with SETTLE, compute err (op>=7 with b==0, or op>=8) and latch it.
  - Go to EXEC.
- EXEC:
  - req_ready=0; the alu_* outputs are held constant.
  - If the counter is 0: capture rsp_data (alu_out, or 0 if err), rsp_comp=alu_comp, rsp_taken, rsp_err; go to RESP.
  - Otherwise decrement the counter.
- RESP:
  - rsp_valid=1; all rsp_* outputs are stable until the handshake.
  - On rsp_valid & rsp_ready, go to IDLE.
  - No new request is accepted in the handshake cycle.
- Error path still passes through EXEC, so rsp_comp is valid for erroneous ops; only rsp_data is zeroed.
- The arithmetic itself is done entirely by the ALU:
  - Results are truncated to DATA_SIZE.
  - DIV truncates toward zero.
- The counter is 4 bits; SETTLE >= 16 is illegal.
- The alu_* outputs keep their last value in IDLE and RESP; no re-drive and no clearing.

## Timing
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - alu_a, alu_b, alu_op, rsp_data, rsp_comp, rsp_taken, rsp_err, and the counter all go to 0.
  - rsp_valid=0; req_ready=1 once rst_n is released.
- Latency: a request accepted at edge N produces rsp_valid high after edge N+SETTLE+1.
  - SETTLE=0 gives 1 cycle.
  - SETTLE=1 gives 2 cycles.
- Throughput: one operation per SETTLE+3 cycles at best (accept, SETTLE+1 exec edges, response handshake, return to IDLE).
- req_ready and rsp_valid are decoded from registered state only; neither depends combinationally on req_valid or rsp_ready.
- Backpressure: rsp_ready low holds RESP indefinitely with outputs frozen; req_ready stays 0.
- Reset mid-EXEC or mid-RESP:
  - The pending operation is discarded.
  - rsp_valid drops immediately (asynchronously).
  - No response is produced after reset release.
- req_valid while not in IDLE is ignored; the requester must hold until req_ready.

## Test plan
- Reset then idle: assert rst_n=0 mid-stream -> rsp_valid=0, alu_op=0, rsp_data=0 immediately; req_ready=1 after release.
- ADD with SETTLE=1, a=3, b=4, cond=001 -> rsp_valid rises 2 edges after accept; rsp_data=7, rsp_comp=001, rsp_taken=1, rsp_err=0.
- MUL a=16'hFFFA (-6), b=3 -> rsp_data=16'hFFEE, rsp_comp=001.
- DIV a=16'hFFF9 (-7), b=2 -> rsp_data=16'hFFFD.
- DIV with b=0, a=5, cond=100 -> rsp_data=0, rsp_err=1, rsp_comp=100, rsp_taken=1.
- Backpressure and reset:
  - Hold rsp_ready=0 for 5 cycles after rsp_valid; drive req_valid the whole time -> rsp_* outputs stable and req_ready=0 throughout; exactly one accept follows the handshake.
  - Pulse rst_n during EXEC -> no response is ever emitted for that op.
